// File: rtl/credit_screen_ctrl_pkg.sv
// rtl/credit_screen_ctrl_pkg.sv - shared screen geometry, colours and mode encodings
package credit_screen_ctrl_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    localparam logic [4:0] COLOR_BLACK = 5'h00;
    localparam logic [4:0] COLOR_WHITE = 5'h1F;

    typedef enum logic [1:0] {
        MODE_TITLE   = 2'd0,
        MODE_PLAY    = 2'd1,
        MODE_CREDITS = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

endpackage

// File: rtl/credit_screen_ctrl_if.sv
// rtl/credit_screen_ctrl_if.sv - frame/pixel bus between video timing, layers and the overlay sequencer
interface credit_screen_ctrl_if;

    logic        frame_tick;
    logic        start_sw;
    logic        game_over;
    logic        video_on;
    logic [4:0]  title_rgb;
    logic [4:0]  credit_rgb;
    logic [4:0]  game_rgb;
    logic [10:0] credit_y;
    logic [1:0]  mode;
    logic [4:0]  rgb_out;

    modport master (
        output frame_tick, start_sw, game_over, video_on, title_rgb, credit_rgb, game_rgb,
        input  credit_y, mode, rgb_out
    );

    modport slave (
        input  frame_tick, start_sw, game_over, video_on, title_rgb, credit_rgb, game_rgb,
        output credit_y, mode, rgb_out
    );

endinterface

// File: rtl/credit_screen_ctrl_frame_divider.sv
// rtl/credit_screen_ctrl_frame_divider.sv - frame_tick-gated modulo counter with terminal pulse
module credit_screen_ctrl_frame_divider (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_i,
    input  logic       clear_i,
    input  logic [7:0] limit_i,
    output logic       terminal_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign terminal_o = tick_i && (count_q == limit_i);

    always_comb begin
        count_d = count_q;
        if (clear_i || terminal_o) begin
            count_d = 8'd0;
        end else if (tick_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/credit_screen_ctrl.sv
// rtl/credit_screen_ctrl.sv - title/play/credits/hold sequencer and registered overlay pixel arbiter
module credit_screen_ctrl
    import credit_screen_ctrl_pkg::*;
#(
    parameter int SCREEN_HEIGHT = credit_screen_ctrl_pkg::SCREEN_HEIGHT,
    parameter int CREDIT_Y_HOME = 440,
    parameter int SCROLL_DIV    = 2,
    parameter int HOLD_FRAMES   = 180,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    credit_screen_ctrl_if.slave  bus
);

    localparam logic [10:0] Y_START   = 11'(SCREEN_HEIGHT);
    localparam logic [10:0] Y_HOME    = 11'(CREDIT_Y_HOME);
    localparam logic [10:0] Y_HOME_P1 = 11'(CREDIT_Y_HOME + 1);
    localparam logic [7:0]  BLINK_LIM  = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0]  SCROLL_LIM = 8'(SCROLL_DIV - 1);
    localparam logic [7:0]  HOLD_LIM   = 8'(HOLD_FRAMES - 1);

    mode_e       mode_q;
    logic [10:0] credit_y_q;
    logic        blink_on_q;
    logic        start_prev_q;
    logic        start_pend_q;
    logic        start_pend_d;
    logic [4:0]  rgb_q;
    logic [4:0]  rgb_d;
    logic [7:0]  div_limit;
    logic        div_clear;
    logic        div_term;

    // A rise landing on a tick cycle survives into the next frame.
    assign start_pend_d = (start_pend_q & ~bus.frame_tick) | (bus.start_sw & ~start_prev_q);

    // Terminal wraps the counter itself; only early exits need an explicit clear.
    assign div_clear = bus.frame_tick && ((mode_q == MODE_PLAY) ? bus.game_over : start_pend_q);

    always_comb begin
        div_limit = 8'd0;
        case (mode_q)
            MODE_TITLE:   div_limit = BLINK_LIM;
            MODE_CREDITS: div_limit = SCROLL_LIM;
            MODE_HOLD:    div_limit = HOLD_LIM;
            default:      div_limit = 8'd0;
        endcase
    end

    credit_screen_ctrl_frame_divider u_div (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (bus.frame_tick),
        .clear_i    (div_clear),
        .limit_i    (div_limit),
        .terminal_o (div_term)
    );

    always_comb begin
        rgb_d = COLOR_BLACK;
        if (bus.video_on) begin
            case (mode_q)
                MODE_TITLE: rgb_d = ((bus.credit_rgb != 5'd0) && blink_on_q) ? bus.credit_rgb : bus.title_rgb;
                MODE_PLAY:  rgb_d = bus.game_rgb;
                default:    rgb_d = bus.credit_rgb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_TITLE;
            credit_y_q   <= Y_HOME;
            blink_on_q   <= 1'b1;
            start_prev_q <= 1'b1;
            start_pend_q <= 1'b0;
            rgb_q        <= COLOR_BLACK;
        end else begin
            start_prev_q <= bus.start_sw;
            start_pend_q <= start_pend_d;
            rgb_q        <= rgb_d;
            if (bus.frame_tick) begin
                case (mode_q)
                    MODE_TITLE: begin
                        if (start_pend_q) begin
                            mode_q <= MODE_PLAY;
                        end else if (div_term) begin
                            blink_on_q <= ~blink_on_q;
                        end
                    end
                    MODE_PLAY: begin
                        if (bus.game_over) begin
                            mode_q     <= MODE_CREDITS;
                            credit_y_q <= Y_START;
                        end
                    end
                    MODE_CREDITS: begin
                        if (start_pend_q) begin
                            mode_q     <= MODE_TITLE;
                            credit_y_q <= Y_HOME;
                            blink_on_q <= 1'b1;
                        end else if (div_term) begin
                            if (credit_y_q <= Y_HOME_P1) begin
                                mode_q     <= MODE_HOLD;
                                credit_y_q <= Y_HOME;
                            end else begin
                                credit_y_q <= credit_y_q - 11'd1;
                            end
                        end
                    end
                    default: begin
                        if (start_pend_q || div_term) begin
                            mode_q     <= MODE_TITLE;
                            blink_on_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.credit_y = credit_y_q;
    assign bus.mode     = mode_q;
    assign bus.rgb_out  = rgb_q;

endmodule

// File: tb/tb_credit_screen_ctrl.sv
// tb/tb_credit_screen_ctrl.sv - directed-vector bench for the credit screen sequencer
module tb_credit_screen_ctrl;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    credit_screen_ctrl_if bus();

    credit_screen_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic pulse();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic test_reset();
        bus.start_sw = 1'b1;
        bus.video_on = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode got %0d want 0", bus.mode); end
        vectors++;
        if (bus.credit_y !== 11'd440) begin miscompares++; $display("FAIL reset_credit_y got %0d want 440", bus.credit_y); end
        vectors++;
        if (bus.rgb_out !== 5'h00) begin miscompares++; $display("FAIL reset_rgb got %h want 00", bus.rgb_out); end
        reset = 1'b0;
        settle();
        pulses(5);
        settle();
        vectors++;
        if (bus.mode !== 2'd0) begin miscompares++; $display("FAIL held_start_mode got %0d want 0", bus.mode); end
        vectors++;
        if (bus.credit_y !== 11'd440) begin miscompares++; $display("FAIL held_start_credit_y got %0d want 440", bus.credit_y); end
    endtask

    task automatic test_blink();
        logic [4:0] exp;
        bus.start_sw   = 1'b0;
        bus.video_on   = 1'b1;
        bus.credit_rgb = 5'h1F;
        bus.title_rgb  = 5'h03;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n <= 60; n++) begin
            settle();
            exp = (((n / 30) % 2) == 0) ? 5'h1F : 5'h03;
            vectors++;
            if (bus.rgb_out !== exp) begin
                miscompares++;
                $display("FAIL blink_tick%0d got %h want %h", n, bus.rgb_out, exp);
            end
            pulse();
        end
        bus.credit_rgb = 5'h00;
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h03) begin miscompares++; $display("FAIL transparent_credit got %h want 03", bus.rgb_out); end
        bus.credit_rgb = 5'h1F;
    endtask

    task automatic test_start_play();
        bus.game_rgb = 5'h0A;
        bus.start_sw = 1'b1;
        repeat (3) settle();
        vectors++;
        if (bus.mode !== 2'd0) begin miscompares++; $display("FAIL start_midframe got %0d want 0", bus.mode); end
        pulse();
        vectors++;
        if (bus.mode !== 2'd1) begin miscompares++; $display("FAIL start_after_tick got %0d want 1", bus.mode); end
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h0A) begin miscompares++; $display("FAIL play_rgb got %h want 0a", bus.rgb_out); end
        bus.video_on = 1'b0;
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h00) begin miscompares++; $display("FAIL blank_rgb got %h want 00", bus.rgb_out); end
        bus.video_on = 1'b1;
        bus.start_sw = 1'b0;
        settle();
    endtask

    task automatic test_credits_scroll();
        logic [10:0] exp_y;
        logic [1:0]  exp_m;
        bus.game_over = 1'b1;
        pulse();
        bus.game_over = 1'b0;
        vectors++;
        if (bus.mode !== 2'd2) begin miscompares++; $display("FAIL credits_enter_mode got %0d want 2", bus.mode); end
        vectors++;
        if (bus.credit_y !== 11'd480) begin miscompares++; $display("FAIL credits_enter_y got %0d want 480", bus.credit_y); end
        for (int k = 1; k <= 80; k++) begin
            pulse();
            exp_y = 11'(480 - (k / 2));
            exp_m = (k == 80) ? 2'd3 : 2'd2;
            vectors++;
            if (bus.credit_y !== exp_y || bus.mode !== exp_m) begin
                miscompares++;
                $display("FAIL scroll_tick%0d got y=%0d mode=%0d want y=%0d mode=%0d", k, bus.credit_y, bus.mode, exp_y, exp_m);
            end
        end
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h1F) begin miscompares++; $display("FAIL hold_credit_rgb got %h want 1f", bus.rgb_out); end
        bus.credit_rgb = 5'h00;
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h00) begin miscompares++; $display("FAIL hold_black_bg got %h want 00", bus.rgb_out); end
        bus.credit_rgb = 5'h1F;
        pulses(179);
        vectors++;
        if (bus.mode !== 2'd3) begin miscompares++; $display("FAIL hold_179 got %0d want 3", bus.mode); end
        pulse();
        vectors++;
        if (bus.mode !== 2'd0) begin miscompares++; $display("FAIL hold_180 got %0d want 0", bus.mode); end
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h1F) begin miscompares++; $display("FAIL hold_exit_blink got %h want 1f", bus.rgb_out); end
    endtask

    task automatic test_skip_and_priority();
        bus.start_sw = 1'b1;
        settle();
        pulse();
        bus.start_sw = 1'b0;
        vectors++;
        if (bus.mode !== 2'd1) begin miscompares++; $display("FAIL skip_setup_play got %0d want 1", bus.mode); end
        bus.game_over = 1'b1;
        pulse();
        bus.game_over = 1'b0;
        pulses(40);
        vectors++;
        if (bus.credit_y !== 11'd460 || bus.mode !== 2'd2) begin
            miscompares++;
            $display("FAIL skip_at460 got y=%0d mode=%0d want y=460 mode=2", bus.credit_y, bus.mode);
        end
        bus.start_sw = 1'b1;
        settle();
        pulse();
        vectors++;
        if (bus.mode !== 2'd0 || bus.credit_y !== 11'd440) begin
            miscompares++;
            $display("FAIL skip_scroll got y=%0d mode=%0d want y=440 mode=0", bus.credit_y, bus.mode);
        end
        bus.start_sw = 1'b0;
        settle();
        bus.start_sw = 1'b1;
        settle();
        pulse();
        bus.start_sw = 1'b0;
        settle();
        bus.start_sw  = 1'b1;
        bus.game_over = 1'b1;
        settle();
        pulse();
        bus.game_over = 1'b0;
        bus.start_sw  = 1'b0;
        vectors++;
        if (bus.mode !== 2'd2) begin miscompares++; $display("FAIL start_vs_gameover got %0d want 2", bus.mode); end
    endtask

    task automatic test_reset_in_hold();
        pulses(80);
        vectors++;
        if (bus.mode !== 2'd3) begin miscompares++; $display("FAIL reach_hold got %0d want 3", bus.mode); end
        pulses(10);
        settle();
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.mode !== 2'd0 || bus.credit_y !== 11'd440 || bus.rgb_out !== 5'h00) begin
            miscompares++;
            $display("FAIL hold_reset got mode=%0d y=%0d rgb=%h want mode=0 y=440 rgb=00", bus.mode, bus.credit_y, bus.rgb_out);
        end
        reset = 1'b0;
        pulses(29);
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h1F) begin miscompares++; $display("FAIL post_reset_29 got %h want 1f", bus.rgb_out); end
        pulse();
        settle();
        vectors++;
        if (bus.rgb_out !== 5'h03) begin miscompares++; $display("FAIL post_reset_30 got %h want 03", bus.rgb_out); end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start_sw   = 1'b0;
        bus.game_over  = 1'b0;
        bus.video_on   = 1'b0;
        bus.title_rgb  = 5'h00;
        bus.credit_rgb = 5'h00;
        bus.game_rgb   = 5'h00;
        @(negedge clk);
        test_reset();
        test_blink();
        test_start_play();
        test_credits_scroll();
        test_skip_and_priority();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
